ext_mem_arbiter: RTL and testbench

//  Shares one external 8-bit async SRAM/PSRAM between the mapper CPU port and PPU port.

---
 rtl/ext_mem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_ext_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ext_mem_arbiter
// Purpose  : Shares one external 8-bit async SRAM/PSRAM between the mapper
//            CPU and PPU ports (PPU priority, CPU anti-starvation).
// Revision : 1.0 - initial release
// ============================================================================
module ext_mem_arbiter #(
  parameter int ACCESS_CYCLES = 3,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        cpu_req_i,
  input  logic [24:0] cpu_addr_i,
  input  logic        cpu_we_i,
  input  logic [7:0]  cpu_wdata_i,
  output logic        cpu_ack_o,
  output logic [7:0]  cpu_rdata_o,
  input  logic        ppu_req_i,
  input  logic [24:0] ppu_addr_i,
  input  logic        ppu_we_i,
  input  logic [7:0]  ppu_wdata_i,
  output logic        ppu_ack_o,
  output logic [7:0]  ppu_rdata_o,
  output logic [24:0] mem_addr_o,
  input  logic [7:0]  mem_din_i,
  output logic [7:0]  mem_dout_o,
  output logic        mem_dq_oe_o,
  output logic        mem_ce_n_o,
  output logic        mem_oe_n_o,
  output logic        mem_we_n_o,
  output logic [1:0]  overrun_o
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ACCESS   = 2'd1;
  localparam logic [1:0] S_DONE     = 2'd2;
  localparam logic [3:0] CNT_LAST   = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] WE_LAST    = 4'(ACCESS_CYCLES - 2);
  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_ppu_q, gnt_ppu_d;
  logic [3:0]  streak_q, streak_d;
  logic        cpu_pend_q, cpu_pend_d, ppu_pend_q, ppu_pend_d;
  logic [24:0] cpu_saddr_q, cpu_saddr_d, ppu_saddr_q, ppu_saddr_d;
  logic        cpu_swe_q, cpu_swe_d, ppu_swe_q, ppu_swe_d;
  logic [7:0]  cpu_swd_q, cpu_swd_d, ppu_swd_q, ppu_swd_d;
  logic        acc_we_q, acc_we_d;
  logic [24:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, dq_oe_q, dq_oe_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d, ppu_rdata_q, ppu_rdata_d;
  logic [1:0]  overrun_q, overrun_d;

  logic        cpu_busy, ppu_busy, cpu_accept, ppu_accept;
  logic        cpu_want, ppu_want, ppu_win, acc_next;
  logic [24:0] cpu_eaddr, ppu_eaddr;
  logic        cpu_ewe, ppu_ewe;
  logic [7:0]  cpu_ewd, ppu_ewd;

  always_comb begin
    // A port stays busy from capture until its ack cycle, so a req on the ack cycle is accepted.
    cpu_busy   = cpu_pend_q | ((state_q == S_ACCESS) & ~gnt_ppu_q);
    ppu_busy   = ppu_pend_q | ((state_q == S_ACCESS) & gnt_ppu_q);
    cpu_accept = cpu_req_i & ~cpu_busy;
    ppu_accept = ppu_req_i & ~ppu_busy;
    cpu_want   = cpu_pend_q | cpu_req_i;
    ppu_want   = ppu_pend_q | ppu_req_i;
    ppu_win    = ppu_want & (~cpu_want | (streak_q != STREAK_MAX));
    cpu_eaddr  = cpu_pend_q ? cpu_saddr_q : cpu_addr_i;
    cpu_ewe    = cpu_pend_q ? cpu_swe_q   : cpu_we_i;
    cpu_ewd    = cpu_pend_q ? cpu_swd_q   : cpu_wdata_i;
    ppu_eaddr  = ppu_pend_q ? ppu_saddr_q : ppu_addr_i;
    ppu_ewe    = ppu_pend_q ? ppu_swe_q   : ppu_we_i;
    ppu_ewd    = ppu_pend_q ? ppu_swd_q   : ppu_wdata_i;

    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_ppu_d   = gnt_ppu_q;
    streak_d    = streak_q;
    acc_we_d    = acc_we_q;
    mem_addr_d  = mem_addr_q;
    mem_dout_d  = mem_dout_q;
    cpu_rdata_d = cpu_rdata_q;
    ppu_rdata_d = ppu_rdata_q;
    cpu_pend_d  = cpu_pend_q | cpu_accept;
    ppu_pend_d  = ppu_pend_q | ppu_accept;
    cpu_saddr_d = cpu_accept ? cpu_addr_i  : cpu_saddr_q;
    cpu_swe_d   = cpu_accept ? cpu_we_i    : cpu_swe_q;
    cpu_swd_d   = cpu_accept ? cpu_wdata_i : cpu_swd_q;
    ppu_saddr_d = ppu_accept ? ppu_addr_i  : ppu_saddr_q;
    ppu_swe_d   = ppu_accept ? ppu_we_i    : ppu_swe_q;
    ppu_swd_d   = ppu_accept ? ppu_wdata_i : ppu_swd_q;
    overrun_d   = overrun_q | {ppu_req_i & ppu_busy, cpu_req_i & cpu_busy};

    case (state_q)
      S_IDLE: begin
        if (cpu_want || ppu_want) begin
          state_d = S_ACCESS;
          cnt_d   = 4'd0;
          if (ppu_win) begin
            gnt_ppu_d  = 1'b1;
            ppu_pend_d = 1'b0;
            mem_addr_d = ppu_eaddr;
            acc_we_d   = ppu_ewe;
            mem_dout_d = ppu_ewd;
            streak_d   = cpu_want ? streak_q + 4'd1 : 4'd0;
          end else begin
            gnt_ppu_d  = 1'b0;
            cpu_pend_d = 1'b0;
            mem_addr_d = cpu_eaddr;
            acc_we_d   = cpu_ewe;
            mem_dout_d = cpu_ewd;
            streak_d   = 4'd0;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          if (!acc_we_q) begin
            if (gnt_ppu_q) ppu_rdata_d = mem_din_i;
            else           cpu_rdata_d = mem_din_i;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pins are registered from next-state so they are glitch-free at the memory.
    acc_next = (state_d == S_ACCESS);
    ce_n_d   = ~acc_next;
    oe_n_d   = ~(acc_next & ~acc_we_d);
    dq_oe_d  = acc_next & acc_we_d;
    we_n_d   = ~(acc_next & acc_we_d & (cnt_d >= 4'd1) & (cnt_d <= WE_LAST));
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      gnt_ppu_q   <= 1'b0;
      streak_q    <= 4'd0;
      cpu_pend_q  <= 1'b0;
      ppu_pend_q  <= 1'b0;
      cpu_saddr_q <= 25'd0;
      cpu_swe_q   <= 1'b0;
      cpu_swd_q   <= 8'd0;
      ppu_saddr_q <= 25'd0;
      ppu_swe_q   <= 1'b0;
      ppu_swd_q   <= 8'd0;
      acc_we_q    <= 1'b0;
      mem_addr_q  <= 25'd0;
      mem_dout_q  <= 8'd0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      cpu_rdata_q <= 8'd0;
      ppu_rdata_q <= 8'd0;
      overrun_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_ppu_q   <= gnt_ppu_d;
      streak_q    <= streak_d;
      cpu_pend_q  <= cpu_pend_d;
      ppu_pend_q  <= ppu_pend_d;
      cpu_saddr_q <= cpu_saddr_d;
      cpu_swe_q   <= cpu_swe_d;
      cpu_swd_q   <= cpu_swd_d;
      ppu_saddr_q <= ppu_saddr_d;
      ppu_swe_q   <= ppu_swe_d;
      ppu_swd_q   <= ppu_swd_d;
      acc_we_q    <= acc_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_dout_q  <= mem_dout_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
      cpu_rdata_q <= cpu_rdata_d;
      ppu_rdata_q <= ppu_rdata_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cpu_ack_o   = (state_q == S_DONE) & ~gnt_ppu_q;
  assign ppu_ack_o   = (state_q == S_DONE) & gnt_ppu_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign ppu_rdata_o = ppu_rdata_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_dout_o  = mem_dout_q;
  assign mem_dq_oe_o = dq_oe_q;
  assign mem_ce_n_o  = ce_n_q;
  assign mem_oe_n_o  = oe_n_q;
  assign mem_we_n_o  = we_n_q;
  assign overrun_o   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_mem_arbiter
// Purpose  : Directed bench for ext_mem_arbiter with a timestamp-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ext_mem_arbiter;
  localparam int N   = 3;
  localparam int LIM = 4;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b0;
  logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0, ppu_req_i = 1'b0, ppu_we_i = 1'b0;
  logic [24:0] cpu_addr_i = '0, ppu_addr_i = '0;
  logic [7:0]  cpu_wdata_i = '0, ppu_wdata_i = '0, mem_din_i = '0;
  logic        cpu_ack_o, ppu_ack_o, mem_dq_oe_o, mem_ce_n_o, mem_oe_n_o, mem_we_n_o;
  logic [7:0]  cpu_rdata_o, ppu_rdata_o, mem_dout_o;
  logic [24:0] mem_addr_o;
  logic [1:0]  overrun_o;

  ext_mem_arbiter #(.ACCESS_CYCLES(N), .STARVE_LIMIT(LIM)) dut (
    .sysclk(sysclk), .reset(reset),
    .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i), .cpu_we_i(cpu_we_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_ack_o(cpu_ack_o), .cpu_rdata_o(cpu_rdata_o),
    .ppu_req_i(ppu_req_i), .ppu_addr_i(ppu_addr_i), .ppu_we_i(ppu_we_i),
    .ppu_wdata_i(ppu_wdata_i), .ppu_ack_o(ppu_ack_o), .ppu_rdata_o(ppu_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_din_i(mem_din_i), .mem_dout_o(mem_dout_o),
    .mem_dq_oe_o(mem_dq_oe_o), .mem_ce_n_o(mem_ce_n_o), .mem_oe_n_o(mem_oe_n_o),
    .mem_we_n_o(mem_we_n_o), .overrun_o(overrun_o)
  );

  always #5 sysclk = ~sysclk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: each grant is a timestamp g; access runs g+1..g+N, ack at g+N+1, next grant >= g+N+2.
  int          cyc = 0;
  bit          m_have;
  int          m_g, m_port, m_streak, m_idle_from;
  logic [24:0] m_addr;
  bit          m_we;
  logic [7:0]  m_wd;
  bit          m_pend [2];
  logic [24:0] s_addr [2];
  bit          s_we [2];
  logic [7:0]  s_wd [2];
  logic [7:0]  m_rdata [2];
  logic [1:0]  m_ovr;

  task automatic model_reset();
    m_have = 0; m_g = 0; m_port = 0; m_streak = 0; m_idle_from = 0;
    m_addr = '0; m_we = 0; m_wd = '0; m_ovr = '0;
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; s_addr[i] = '0; s_we[i] = 0; s_wd[i] = '0; m_rdata[i] = '0;
    end
  endtask

  initial begin : b_model
    logic        rq [2];
    logic [24:0] ra [2];
    logic        rw [2];
    logic [7:0]  rd [2];
    bit          busy;
    int          p;
    model_reset();
    forever begin
      @(posedge sysclk);
      if (!reset) begin
        model_reset();
      end else begin
        rq[0] = cpu_req_i; ra[0] = cpu_addr_i; rw[0] = cpu_we_i; rd[0] = cpu_wdata_i;
        rq[1] = ppu_req_i; ra[1] = ppu_addr_i; rw[1] = ppu_we_i; rd[1] = ppu_wdata_i;
        if (m_have && cyc == m_g + N && !m_we) m_rdata[m_port] = mem_din_i;
        for (int i = 0; i < 2; i++) begin
          busy = m_pend[i] || (m_have && m_port == i && cyc >= m_g + 1 && cyc <= m_g + N);
          if (rq[i]) begin
            if (busy) m_ovr[i] = 1'b1;
            else begin
              m_pend[i] = 1; s_addr[i] = ra[i]; s_we[i] = rw[i]; s_wd[i] = rd[i];
            end
          end
        end
        if (cyc >= m_idle_from && (m_pend[0] || m_pend[1])) begin
          p = (m_pend[1] && !(m_pend[0] && m_streak == LIM)) ? 1 : 0;
          if (p == 1) m_streak = m_pend[0] ? ((m_streak + 1 > LIM) ? LIM : m_streak + 1) : 0;
          else        m_streak = 0;
          m_have = 1; m_g = cyc; m_port = p;
          m_addr = s_addr[p]; m_we = s_we[p]; m_wd = s_wd[p];
          m_pend[p] = 0; m_idle_from = cyc + N + 2;
        end
      end
      cyc++;
    end
  end

  initial begin : b_compare
    bit         act;
    int         off;
    logic [1:0] e_ack;
    forever begin
      @(negedge sysclk);
      if (!reset) model_reset();
      act   = m_have && cyc >= m_g + 1 && cyc <= m_g + N;
      off   = cyc - m_g - 1;
      e_ack = 2'b00;
      if (m_have && cyc == m_g + N + 1) e_ack[m_port] = 1'b1;
      chk("ce_n",  32'(mem_ce_n_o),  32'(!act));
      chk("oe_n",  32'(mem_oe_n_o),  32'(!(act && !m_we)));
      chk("we_n",  32'(mem_we_n_o),  32'(!(act && m_we && off >= 1 && off <= N - 2)));
      chk("dq_oe", 32'(mem_dq_oe_o), 32'(act && m_we));
      chk("acks",  32'({ppu_ack_o, cpu_ack_o}), 32'(e_ack));
      chk("mem_addr",  32'(mem_addr_o),  32'(m_addr));
      chk("cpu_rdata", 32'(cpu_rdata_o), 32'(m_rdata[0]));
      chk("ppu_rdata", 32'(ppu_rdata_o), 32'(m_rdata[1]));
      chk("overrun",   32'(overrun_o),   32'(m_ovr));
      if (act && m_we) chk("mem_dout", 32'(mem_dout_o), 32'(m_wd));
    end
  end

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cpu_req_i = 0; ppu_req_i = 0; cpu_we_i = 0; ppu_we_i = 0;
    repeat (2) step();
    reset = 1'b1;
    step();
  endtask

  initial begin : b_stim
    int ppu_before, cpu_seen, resumed;

    // Test 1: CPU read
    do_reset();
    chk("reset ce_n", 32'(mem_ce_n_o), 32'd1);
    chk("reset overrun", 32'(overrun_o), 32'd0);
    mem_din_i = 8'hA5;
    cpu_req_i = 1; cpu_addr_i = 25'h0000ABC; cpu_we_i = 0;
    step(); cpu_req_i = 0;
    chk("t1 ce_n c1", 32'(mem_ce_n_o), 32'd0);
    chk("t1 oe_n c1", 32'(mem_oe_n_o), 32'd0);
    step(); step();
    chk("t1 ce_n c3", 32'(mem_ce_n_o), 32'd0);
    chk("t1 ack c3", 32'(cpu_ack_o), 32'd0);
    step();
    chk("t1 ack c4", 32'(cpu_ack_o), 32'd1);
    chk("t1 rdata c4", 32'(cpu_rdata_o), 32'hA5);
    step(); mem_din_i = 8'h00;
    chk("t1 ack c5", 32'(cpu_ack_o), 32'd0);
    chk("t1 ce_n c5", 32'(mem_ce_n_o), 32'd1);
    step();
    chk("t1 rdata held", 32'(cpu_rdata_o), 32'hA5);

    // Test 2: CPU write
    do_reset();
    cpu_req_i = 1; cpu_addr_i = 25'h100123; cpu_we_i = 1; cpu_wdata_i = 8'h3C;
    step(); cpu_req_i = 0; cpu_we_i = 0;
    chk("t2 addr c1", 32'(mem_addr_o), 32'h100123);
    chk("t2 dq_oe c1", 32'(mem_dq_oe_o), 32'd1);
    chk("t2 we_n c1", 32'(mem_we_n_o), 32'd1);
    step();
    chk("t2 we_n c2", 32'(mem_we_n_o), 32'd0);
    chk("t2 oe_n c2", 32'(mem_oe_n_o), 32'd1);
    chk("t2 dout c2", 32'(mem_dout_o), 32'h3C);
    step();
    chk("t2 we_n c3", 32'(mem_we_n_o), 32'd1);
    chk("t2 dq_oe c3", 32'(mem_dq_oe_o), 32'd1);
    step();
    chk("t2 ack c4", 32'(cpu_ack_o), 32'd1);
    chk("t2 dq_oe c4", 32'(mem_dq_oe_o), 32'd0);

    // Test 3: simultaneous requests, PPU first
    do_reset();
    mem_din_i = 8'h11;
    cpu_req_i = 1; cpu_addr_i = 25'h0000200; cpu_we_i = 0;
    ppu_req_i = 1; ppu_addr_i = 25'h1FFFFFF; ppu_we_i = 0;
    step(); cpu_req_i = 0; ppu_req_i = 0;
    chk("t3 addr c1", 32'(mem_addr_o), 32'h1FFFFFF);
    step(); step(); step();
    chk("t3 ppu_ack c4", 32'(ppu_ack_o), 32'd1);
    chk("t3 cpu_ack c4", 32'(cpu_ack_o), 32'd0);
    chk("t3 ppu_rdata c4", 32'(ppu_rdata_o), 32'h11);
    mem_din_i = 8'h22;
    step();
    chk("t3 ce_n c5", 32'(mem_ce_n_o), 32'd1);
    step();
    chk("t3 addr c6", 32'(mem_addr_o), 32'h0000200);
    chk("t3 ce_n c6", 32'(mem_ce_n_o), 32'd0);
    step(); step(); step();
    chk("t3 cpu_ack c9", 32'(cpu_ack_o), 32'd1);
    chk("t3 cpu_rdata c9", 32'(cpu_rdata_o), 32'h22);
    chk("t3 ppu_rdata kept", 32'(ppu_rdata_o), 32'h11);

    // Test 4: anti-starvation
    do_reset();
    mem_din_i = 8'h77;
    cpu_req_i = 1; cpu_addr_i = 25'h0000300;
    ppu_req_i = 1; ppu_addr_i = 25'h0000400;
    step(); cpu_req_i = 0; ppu_req_i = 0;
    ppu_before = 0; cpu_seen = 0; resumed = 0;
    for (int k = 0; k < 80 && resumed == 0; k++) begin
      ppu_req_i = 0;
      if (ppu_ack_o) begin
        if (cpu_seen == 0) begin
          ppu_before++;
          ppu_req_i = 1;
        end else begin
          resumed = 1;
        end
      end
      if (cpu_ack_o) cpu_seen = 1;
      step();
    end
    ppu_req_i = 0;
    chk("t4 ppu grants before cpu", 32'(ppu_before), 32'd4);
    chk("t4 cpu served", 32'(cpu_seen), 32'd1);
    chk("t4 ppu resumed", 32'(resumed), 32'd1);

    // Test 5: overrun and request on ack cycle
    do_reset();
    mem_din_i = 8'h5C;
    cpu_req_i = 1; cpu_addr_i = 25'h0000500; cpu_we_i = 0;
    step(); cpu_req_i = 0;
    step();
    cpu_req_i = 1; cpu_addr_i = 25'h0000600;
    step(); cpu_req_i = 0;
    chk("t5 overrun c3", 32'(overrun_o), 32'd1);
    chk("t5 addr c3", 32'(mem_addr_o), 32'h0000500);
    step();
    chk("t5 ack c4", 32'(cpu_ack_o), 32'd1);
    cpu_req_i = 1; cpu_addr_i = 25'h0000700;
    step(); cpu_req_i = 0;
    chk("t5 ack c5", 32'(cpu_ack_o), 32'd0);
    chk("t5 ce_n c5", 32'(mem_ce_n_o), 32'd1);
    step();
    chk("t5 addr c6", 32'(mem_addr_o), 32'h0000700);
    step(); step();
    chk("t5 ack c8", 32'(cpu_ack_o), 32'd0);
    step();
    chk("t5 ack c9", 32'(cpu_ack_o), 32'd1);

    // Test 6: reset mid-access
    do_reset();
    cpu_req_i = 1; cpu_addr_i = 25'h0000800; cpu_we_i = 1; cpu_wdata_i = 8'h99;
    step();
    step(); cpu_req_i = 0; cpu_we_i = 0;
    chk("t6 we_n c2", 32'(mem_we_n_o), 32'd0);
    chk("t6 overrun c2", 32'(overrun_o), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("t6 rst ce_n", 32'(mem_ce_n_o), 32'd1);
    chk("t6 rst oe_n", 32'(mem_oe_n_o), 32'd1);
    chk("t6 rst we_n", 32'(mem_we_n_o), 32'd1);
    chk("t6 rst dq_oe", 32'(mem_dq_oe_o), 32'd0);
    chk("t6 rst acks", 32'({ppu_ack_o, cpu_ack_o}), 32'd0);
    chk("t6 rst overrun", 32'(overrun_o), 32'd0);
    step(); step();
    reset = 1'b1;
    repeat (6) begin
      step();
      chk("t6 idle ce_n", 32'(mem_ce_n_o), 32'd1);
      chk("t6 idle acks", 32'({ppu_ack_o, cpu_ack_o}), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
